seq_match_logger: RTL and testbench

//  Sits directly downstream of sequence_detector. Consumes its one-bit match output z and

---
 rtl/seq_match_logger.sv | 166 ++++++++++++++++
 tb/tb_seq_match_logger.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_logger.sv
// -----------------------------------------------------------------------------
// seq_match_logger
// Timestamps every match event from sequence_detector against a free-running
// cycle counter. Timestamps are queued in a small first-word-fall-through FIFO
// and drained over a valid/ready interface. The block also keeps a saturating
// match counter and a sticky overflow flag.
//
// Optional feature macro: SEQ_LOG_EDGE_EN
//   defined   -> an event is a rising edge of z_in (uses a registered z_prev)
//   undefined -> every cycle with z_in=1 is an event
// -----------------------------------------------------------------------------
module seq_match_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     z_in,
    input  logic                     clr,
    output logic [TS_W-1:0]          ts_out,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ZERO_LVL = {LVL_W{1'b0}};

    logic [TS_W-1:0]  ts_cnt_r;
    logic [TS_W-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic [TS_W-1:0]  ts_out_r;
    logic             ts_valid_r;
    logic [CNT_W-1:0] match_cnt_r;
    logic             overflow_r;

    logic             event_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [LVL_W-1:0] level_after_pop_s;
    logic [LVL_W-1:0] level_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [TS_W-1:0]  head_nxt_s;

`ifdef SEQ_LOG_EDGE_EN
    logic             z_prev_r;

    // Previous z_in sample for rising-edge detection; deliberately untouched by clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_prev_r <= 1'b0;
        end else begin
            z_prev_r <= z_in;
        end
    end

    // A run of highs counts once: only the 0->1 transition is an event.
    always_comb begin
        event_s = z_in & ~z_prev_r;
    end
`else
    // Every sampled high is its own event.
    always_comb begin
        event_s = z_in;
    end
`endif

    // Push/pop/drop decisions and the next FIFO head for the registered ts_out.
    always_comb begin
        full_s = (level_r == FULL_LVL);
        pop_s  = 1'b0;
        push_s = 1'b0;
        drop_s = 1'b0;
        if (clr) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
            drop_s = 1'b0;
        end else begin
            // ts_ready only counts while something is queued.
            pop_s  = (level_r != ZERO_LVL) && ts_ready;
            // A pop in the same cycle frees the slot a full FIFO needs.
            push_s = event_s && (!full_s || pop_s);
            drop_s = event_s && full_s && !pop_s;
        end

        level_after_pop_s = level_r - LVL_W'(pop_s);
        level_nxt_s       = level_after_pop_s + LVL_W'(push_s);
        rd_ptr_nxt_s      = rd_ptr_r + PTR_W'(pop_s);

        // ts_out is registered, so look ahead: the head after this edge is either
        // an entry already in memory or, if the FIFO drains to nothing, the
        // timestamp being pushed right now (not yet visible in mem_r).
        head_nxt_s = ts_out_r;
        if (clr) begin
            head_nxt_s = ts_out_r;
        end else if (level_after_pop_s == ZERO_LVL) begin
            if (push_s) begin
                head_nxt_s = ts_cnt_r;
            end else begin
                head_nxt_s = ts_out_r;
            end
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Timestamp counter, FIFO storage/pointers, status counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt_r    <= {TS_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            level_r     <= ZERO_LVL;
            ts_out_r    <= {TS_W{1'b0}};
            ts_valid_r  <= 1'b0;
            match_cnt_r <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {TS_W{1'b0}};
            end
        end else begin
            // The timestamp base keeps running through clr.
            ts_cnt_r <= ts_cnt_r + {{(TS_W-1){1'b0}}, 1'b1};
            if (clr) begin
                wr_ptr_r    <= {PTR_W{1'b0}};
                rd_ptr_r    <= {PTR_W{1'b0}};
                level_r     <= ZERO_LVL;
                ts_valid_r  <= 1'b0;
                match_cnt_r <= {CNT_W{1'b0}};
                overflow_r  <= 1'b0;
            end else begin
                if (push_s) begin
                    mem_r[wr_ptr_r] <= ts_cnt_r;
                    wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                rd_ptr_r   <= rd_ptr_nxt_s;
                level_r    <= level_nxt_s;
                ts_valid_r <= (level_nxt_s != ZERO_LVL);
                // Every event is counted, whether or not the FIFO had room.
                if (event_s && (match_cnt_r != {CNT_W{1'b1}})) begin
                    match_cnt_r <= match_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
            ts_out_r <= head_nxt_s;
        end
    end

    assign ts_out     = ts_out_r;
    assign ts_valid   = ts_valid_r;
    assign match_cnt  = match_cnt_r;
    assign fifo_level = level_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_seq_match_logger.sv
// -----------------------------------------------------------------------------
// tb_seq_match_logger
// Scoreboard bench: expected timestamps are queued when an accepted event is
// driven and popped/compared when the DUT hands them out. Narrow TS_W/CNT_W
// make counter wrap and match_cnt saturation reachable in a short run.
// Follows SEQ_LOG_EDGE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_seq_match_logger;

    localparam int TS_W  = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             z_in;
    logic             clr;
    logic [TS_W-1:0]  ts_out;
    logic             ts_valid;
    logic             ts_ready;
    logic [CNT_W-1:0] match_cnt;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;

    seq_match_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .z_in       (z_in),
        .clr        (clr),
        .ts_out     (ts_out),
        .ts_valid   (ts_valid),
        .ts_ready   (ts_ready),
        .match_cnt  (match_cnt),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [TS_W-1:0]  m_ts;
    logic [TS_W-1:0]  m_out;
    logic [TS_W-1:0]  sb_q[$];
    int               m_cnt;
    logic             m_ovf;
    logic             m_zprev;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Compare every output with the model after an edge.
    task automatic check_outputs(input string tag);
        check_val({tag, ".valid"}, 32'(ts_valid), 32'(sb_q.size() != 0));
        check_val({tag, ".level"}, 32'(fifo_level), 32'(sb_q.size()));
        check_val({tag, ".cnt"},   32'(match_cnt), 32'(m_cnt));
        check_val({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
        check_val({tag, ".out"},   32'(ts_out), 32'(m_out));
    endtask

    // Drive one cycle, advance the model, then check after the edge.
    task automatic cyc(input logic z, input logic rdy, input logic c, input string tag);
        logic ev;
        logic pop;
        logic [TS_W-1:0] exp_ts;
        z_in     = z;
        ts_ready = rdy;
        clr      = c;
`ifdef SEQ_LOG_EDGE_EN
        ev = z && !m_zprev;
`else
        ev = z;
`endif
        pop = (sb_q.size() != 0) && rdy && !c;
        if (pop) begin
            // Consumer takes the current head: it must match the oldest expected entry.
            exp_ts = sb_q.pop_front();
            check_val({tag, ".pop"}, 32'(ts_out), 32'(exp_ts));
        end
        if (c) begin
            sb_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (ev) begin
            if (sb_q.size() < DEPTH) sb_q.push_back(m_ts);
            else m_ovf = 1'b1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        m_zprev = z;
        m_ts    = m_ts + 8'd1;
        @(posedge clk);
        #1;
        if (sb_q.size() != 0) m_out = sb_q[0];
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; z_in = 1'b0; clr = 1'b0; ts_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        sb_q.delete();
        m_cnt = 0; m_ovf = 1'b0; m_zprev = 1'b0; m_ts = 8'd0; m_out = 8'd0;
        check_outputs("reset");
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // 1: single pulse at ts_cnt=5.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, "t1_idle");
        cyc(1'b1, 1'b0, 1'b0, "t1_ev");
        check_val("t1_ts5", 32'(ts_out), 32'd5);
        check_val("t1_lvl", 32'(fifo_level), 32'd1);

        // 2: pop the single entry.
        cyc(1'b0, 1'b1, 1'b0, "t2_pop");
        check_val("t2_valid", 32'(ts_valid), 32'd0);
        check_val("t2_cnt", 32'(match_cnt), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, "t2_ready_empty");

        // 3: five pulses two cycles apart, one is dropped; then drain.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, "t3_ev");
            cyc(1'b0, 1'b0, 1'b0, "t3_gap");
        end
        check_val("t3_lvl", 32'(fifo_level), 32'd4);
        check_val("t3_ovf", 32'(overflow), 32'd1);
        check_val("t3_cnt", 32'(match_cnt), 32'd6);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, "t3_drain");
        check_val("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4: full FIFO, push and pop in the same cycle.
        cyc(1'b0, 1'b0, 1'b1, "t4_clr");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, "t4_fill");
            cyc(1'b0, 1'b0, 1'b0, "t4_gap");
        end
        cyc(1'b1, 1'b1, 1'b0, "t4_pushpop");
        check_val("t4_lvl", 32'(fifo_level), 32'd4);
        check_val("t4_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, "t4_drain");

        // 5: two entries with overflow set, then clr together with an event.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, "t5_fill");
            cyc(1'b0, 1'b0, 1'b0, "t5_gap");
        end
        cyc(1'b0, 1'b1, 1'b0, "t5_pop");
        cyc(1'b0, 1'b1, 1'b0, "t5_pop");
        check_val("t5_lvl2", 32'(fifo_level), 32'd2);
        cyc(1'b1, 1'b1, 1'b1, "t5_clr");
        check_val("t5_lvl", 32'(fifo_level), 32'd0);
        check_val("t5_cnt", 32'(match_cnt), 32'd0);
        check_val("t5_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, "t5_after");

        // 6: z_in held high for three cycles.
        cyc(1'b1, 1'b0, 1'b0, "t6_hi");
        cyc(1'b1, 1'b0, 1'b0, "t6_hi");
        cyc(1'b1, 1'b0, 1'b0, "t6_hi");
        cyc(1'b0, 1'b0, 1'b0, "t6_lo");
`ifdef SEQ_LOG_EDGE_EN
        check_val("t6_lvl", 32'(fifo_level), 32'd1);
`else
        check_val("t6_lvl", 32'(fifo_level), 32'd3);
`endif
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, "t6_drain");

        // match_cnt saturation (CNT_W=3 -> 7).
        cyc(1'b0, 1'b0, 1'b1, "sat_clr");
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, "sat_ev");
            cyc(1'b0, 1'b1, 1'b0, "sat_gap");
        end
        check_val("sat_cnt", 32'(match_cnt), 32'd7);

        // Timestamp wrap past 2^TS_W-1.
        for (int i = 0; i < 260; i++) cyc(1'b0, 1'b0, 1'b0, "wrap_idle");
        cyc(1'b1, 1'b0, 1'b0, "wrap_ev");
        cyc(1'b0, 1'b1, 1'b0, "wrap_pop");

        // Random traffic with occasional clr.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 40) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
